// File: rtl/arbiter_puf_reader_if.sv
// Request/response and mux-chain signals of the arbiter PUF reader.
// The requester drives start/chal_seed; puf_resp comes from the arbiter.
interface arbiter_puf_reader_if #(
    parameter int CHAL_W = 64,
    parameter int RESP_W = 8
) ();
    logic                         start;
    logic [CHAL_W-1:0]            chal_seed;
    logic                         busy;
    logic                         done;
    logic [RESP_W-1:0]            response;
    logic [$clog2(RESP_W+1)-1:0]  unstable;
    logic [CHAL_W-1:0]            puf_chal;
    logic                         puf_launch;
    logic                         puf_resp;

    modport master (
        output start, chal_seed, puf_resp,
        input  busy, done, response, unstable, puf_chal, puf_launch
    );

    modport slave (
        input  start, chal_seed, puf_resp,
        output busy, done, response, unstable, puf_chal, puf_launch
    );
endinterface

// File: rtl/arbiter_puf_reader.sv
// Arbiter PUF evaluation controller: launches repeated races per challenge,
// majority-votes each response bit and counts bits whose votes disagreed.
module arbiter_puf_reader #(
    parameter int CHAL_W = 64,
    parameter int RESP_W = 8,
    parameter int VOTES  = 7,
    parameter int SETTLE = 4
) (
    input logic               clk,
    input logic               rst_n,
    arbiter_puf_reader_if.slave bus
);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int VW = (VOTES > 1) ? $clog2(VOTES) : 1;
    localparam int BW = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int OW = $clog2(VOTES + 1);
    localparam int UW = $clog2(RESP_W + 1);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [VW-1:0] VOTE_LAST   = VW'(VOTES - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(RESP_W - 1);
    localparam logic [OW-1:0] VOTE_HALF   = OW'(VOTES / 2);
    localparam logic [OW-1:0] VOTE_ALL    = OW'(VOTES);

    typedef enum logic [2:0] {IDLE, ARM, RACE, DECIDE, DONE} state_t;

    state_t            state;
    logic [SW-1:0]     settle_cnt;
    logic [VW-1:0]     vote_idx;
    logic [BW-1:0]     bit_idx;
    logic [OW-1:0]     ones;
    logic [RESP_W-1:0] word;
    logic [UW-1:0]     unstable_acc;

    logic              busy_q;
    logic              done_q;
    logic              launch_q;
    logic [CHAL_W-1:0] chal_q;
    logic [RESP_W-1:0] response_q;
    logic [UW-1:0]     unstable_q;

    logic              vote_bit;
    logic              split;
    logic [RESP_W-1:0] word_next;
    logic [UW-1:0]     acc_next;

    assign vote_bit = (ones > VOTE_HALF);
    assign split    = (ones != '0) && (ones != VOTE_ALL);
    assign acc_next = unstable_acc + UW'(split);

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (a latch).
    always_comb begin
        word_next          = word;
        word_next[bit_idx] = vote_bit;
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            vote_idx     <= '0;
            bit_idx      <= '0;
            ones         <= '0;
            word         <= '0;
            unstable_acc <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            launch_q     <= 1'b0;
            chal_q       <= '0;
            response_q   <= '0;
            unstable_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                // DONE lasts one cycle; a start seen there begins the next request right away.
                IDLE, DONE: begin
                    if (bus.start) begin
                        chal_q       <= bus.chal_seed;
                        settle_cnt   <= '0;
                        vote_idx     <= '0;
                        bit_idx      <= '0;
                        ones         <= '0;
                        word         <= '0;
                        unstable_acc <= '0;
                        busy_q       <= 1'b1;
                        state        <= ARM;
                    end else begin
                        state <= IDLE;
                    end
                end
                ARM: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        launch_q   <= 1'b1;
                        state      <= RACE;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                RACE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        launch_q   <= 1'b0;
                        ones       <= ones + OW'(bus.puf_resp);
                        if (vote_idx == VOTE_LAST) begin
                            state <= DECIDE;
                        end else begin
                            vote_idx <= vote_idx + VW'(1);
                            state    <= ARM;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                DECIDE: begin
                    word         <= word_next;
                    unstable_acc <= acc_next;
                    ones         <= '0;
                    vote_idx     <= '0;
                    if (bit_idx == BIT_LAST) begin
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        response_q <= word_next;
                        unstable_q <= acc_next;
                        state      <= DONE;
                    end else begin
                        // Rotating by one per bit keeps puf_chal equal to seed rotated by bit_idx.
                        bit_idx <= bit_idx + BW'(1);
                        chal_q  <= {chal_q[CHAL_W-2:0], chal_q[CHAL_W-1]};
                        state   <= ARM;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.puf_launch = launch_q;
    assign bus.puf_chal   = chal_q;
    assign bus.response   = response_q;
    assign bus.unstable   = unstable_q;
endmodule

// File: tb/tb_arbiter_puf_reader.sv
// Directed bench for arbiter_puf_reader: cycle-exact checks of handshake,
// launch waveform, challenge rotation, voting results and async reset.
module tb_arbiter_puf_reader;
    localparam int CHAL_W   = 64;
    localparam int RESP_W   = 8;
    localparam int VOTES    = 7;
    localparam int SETTLE   = 4;
    localparam int VOTE_CYC = 2 * SETTLE;
    localparam int BIT_CYC  = VOTES * VOTE_CYC + 1;
    localparam int EVAL_CYC = RESP_W * BIT_CYC;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] prev_resp = 8'h00;
    logic [3:0] prev_unst = 4'h0;

    arbiter_puf_reader_if #(.CHAL_W(CHAL_W), .RESP_W(RESP_W)) bus ();

    arbiter_puf_reader #(
        .CHAL_W(CHAL_W), .RESP_W(RESP_W), .VOTES(VOTES), .SETTLE(SETTLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rotl(input logic [63:0] s, input int n);
        int m;
        m = n % 64;
        return (m == 0) ? s : ((s << m) | (s >> (64 - m)));
    endfunction

    // Chain model: value presented for edge e (relative to the start edge).
    function automatic logic model_resp(input int mode, input logic [63:0] seed, input int e);
        int b;
        int o;
        int j;
        logic [63:0] r;
        b = e / BIT_CYC;
        o = e % BIT_CYC;
        j = (o % VOTE_CYC == 0) ? (o / VOTE_CYC - 1) : -1;
        r = rotl(seed, b);
        case (mode)
            0:       return 1'b1;
            1:       return r[7];
            2:       return (j >= 0) && (j < 3);
            3:       return (j >= 0) && (j < 4);
            default: return 1'b0;
        endcase
    endfunction

    // Called #1 after an edge; the start is accepted on the next edge (k=0).
    task automatic run_eval(input logic [63:0] seed, input int mode, input logic [7:0] exp_resp,
                            input logic [3:0] exp_unst, input bit hold_start, input bit pulse_start);
        int busy_cycles;
        int done_cycles;
        int b;
        bit in_eval;
        busy_cycles   = 0;
        done_cycles   = 0;
        bus.chal_seed = seed;
        bus.start     = 1'b1;
        bus.puf_resp  = model_resp(mode, seed, 0);
        @(posedge clk);
        #1;
        bus.start = hold_start;
        for (int k = 0; k <= EVAL_CYC; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            in_eval = (k < EVAL_CYC);
            b = in_eval ? k / BIT_CYC : RESP_W - 1;
            check($sformatf("busy@%0d", k), 64'(bus.busy), 64'(in_eval));
            check($sformatf("done@%0d", k), 64'(bus.done), 64'(!in_eval));
            check($sformatf("launch@%0d", k), 64'(bus.puf_launch),
                  64'(in_eval && ((k % BIT_CYC) % VOTE_CYC >= SETTLE)));
            check($sformatf("chal@%0d", k), bus.puf_chal, rotl(seed, b));
            check($sformatf("resp@%0d", k), 64'(bus.response), 64'(in_eval ? prev_resp : exp_resp));
            check($sformatf("unst@%0d", k), 64'(bus.unstable), 64'(in_eval ? prev_unst : exp_unst));
            busy_cycles += int'(bus.busy);
            done_cycles += int'(bus.done);
            bus.puf_resp = model_resp(mode, seed, k + 1);
            if (pulse_start) bus.start = (k % 37 == 5) && (k < EVAL_CYC - 2);
        end
        check("busy_cycles", 64'(busy_cycles), 64'(EVAL_CYC));
        check("done_pulses", 64'(done_cycles), 64'd1);
        prev_resp = exp_resp;
        prev_unst = exp_unst;
    endtask

    task automatic idle_check(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            check("idle_busy", 64'(bus.busy), 64'd0);
            check("idle_done", 64'(bus.done), 64'd0);
            check("idle_launch", 64'(bus.puf_launch), 64'd0);
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.chal_seed = '0;
        bus.puf_resp  = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_launch", 64'(bus.puf_launch), 64'd0);
        check("rst_chal", bus.puf_chal, 64'd0);
        check("rst_resp", 64'(bus.response), 64'd0);
        check("rst_unst", 64'(bus.unstable), 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle_check(2);

        run_eval(64'h1, 0, 8'hFF, 4'd0, 1'b0, 1'b0);
        idle_check(3);
        run_eval(64'h8000_0000_0000_001E, 1, 8'h78, 4'd0, 1'b0, 1'b0);
        idle_check(2);
        run_eval(64'h0123_4567_89AB_CDEF, 2, 8'h00, 4'd8, 1'b0, 1'b0);
        idle_check(2);
        run_eval(64'hF0F0_0000_0000_0F0F, 3, 8'hFF, 4'd8, 1'b0, 1'b0);
        idle_check(2);

        // Asynchronous reset in the middle of a race of bit 2.
        bus.chal_seed = 64'hDEAD_BEEF_0000_00FF;
        bus.start     = 1'b1;
        bus.puf_resp  = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2 * BIT_CYC + SETTLE + 1) @(posedge clk);
        #1;
        check("pre_rst_launch", 64'(bus.puf_launch), 64'd1);
        check("pre_rst_busy", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_launch", 64'(bus.puf_launch), 64'd0);
        check("mid_rst_chal", bus.puf_chal, 64'd0);
        check("mid_rst_resp", 64'(bus.response), 64'd0);
        check("mid_rst_unst", 64'(bus.unstable), 64'd0);
        check("mid_rst_done", 64'(bus.done), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        prev_resp = 8'h00;
        prev_unst = 4'd0;
        @(posedge clk);
        #1;
        check("post_rst_done", 64'(bus.done), 64'd0);
        check("post_rst_busy", 64'(bus.busy), 64'd0);
        idle_check(1);

        run_eval(64'h1E, 1, 8'h78, 4'd0, 1'b0, 1'b0);
        idle_check(2);

        // start pulses while busy must be ignored.
        run_eval(64'h5, 0, 8'hFF, 4'd0, 1'b0, 1'b1);
        idle_check(4);

        // start held through DONE: back-to-back evaluation from edge 457.
        run_eval(64'h1E, 1, 8'h78, 4'd0, 1'b1, 1'b0);
        run_eval(64'h1, 0, 8'hFF, 4'd0, 1'b0, 1'b0);
        idle_check(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
